des_network_face_adapter: RTL and testbench

Parametrised edge adapter that terminates one face of the mesh network core (X− / X+ / Y− / Y+) and presents it to a host agent as a single injection stream and a single ejection stream. It owns the credit-based flow control the mesh expects at its boundary: per-channel downstream credit counters for injection, and per-channel receive FIFOs with credit return for ejection. It replaces hand-wired per-port glue around the network core with one block sized by channel count, flit width and buffer depth.

---
 rtl/des_network_face_adapter_pkg.sv | 22 ++
 rtl/des_network_face_adapter_face_fifo.sv | 61 ++++++
 rtl/des_network_face_adapter.sv | 187 ++++++++++++++++++
 tb/tb_des_network_face_adapter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_network_face_adapter_pkg.sv
// Shared constants and helpers for the mesh face adapter.
// Default flit width, position of the per-flit valid flag, and a
// constant clog2 used to size selector, pointer and credit fields.
package des_network_face_adapter_pkg;

  // Default flit width; the top bit of every flit is its valid flag.
  localparam int DEF_CHANNEL_WIDTH = 16;

  // Bit position of the valid flag inside a flit of the given width.
  function automatic int flag_pos_f(input int width);
    return width - 1;
  endfunction

  // Ceiling log2 usable in parameter and port-width expressions.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/des_network_face_adapter_face_fifo.sv
// Single-channel synchronous FIFO holding flits ejected from one mesh channel.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module face_fifo
  import des_network_face_adapter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2_f(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one wrap bit so full and empty can be told apart.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en     = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign wr_en     = push_i && (!full_o || rd_en);
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance each pointer when its side of the FIFO moves.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; clearing them discards any buffered flits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Flit storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/des_network_face_adapter.sv
// Terminates one mesh face: credit-gated injection and buffered round-robin ejection.
// Latency: injection 1 cycle; ejection 2 cycles to host_rx_valid, credit return 1 cycle after the pop.
// Backpressure: host_tx_ready follows the selected channel's credits; host_rx_ready=0 holds the output register.
module des_network_face_adapter
  import des_network_face_adapter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter int BUFFER_DEPTH  = 4,
  parameter int CREDITS       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CHANNELS*CHANNEL_WIDTH-1:0] mesh_in_channels,
  output logic [CHANNELS-1:0]               mesh_in_credits,
  output logic [CHANNELS*CHANNEL_WIDTH-1:0] mesh_out_channels,
  input  logic [CHANNELS-1:0]               mesh_out_credits,
  input  logic [CHANNEL_WIDTH-1:0]          host_tx_data,
  input  logic [clog2_f(CHANNELS)-1:0]      host_tx_sel,
  input  logic                              host_tx_valid,
  output logic                              host_tx_ready,
  output logic [CHANNEL_WIDTH-1:0]          host_rx_data,
  output logic [clog2_f(CHANNELS)-1:0]      host_rx_sel,
  output logic                              host_rx_valid,
  input  logic                              host_rx_ready,
  output logic                              proto_err
);

  localparam int W  = CHANNEL_WIDTH;
  localparam int VB = flag_pos_f(CHANNEL_WIDTH);
  localparam int SW = clog2_f(CHANNELS);
  localparam int CW = clog2_f(CREDITS + 1);

  // ---------------- injection side ----------------
  logic [CW-1:0]         credit_q [CHANNELS];
  logic [CW-1:0]         credit_d [CHANNELS];
  logic [CHANNELS*W-1:0] mesh_out_q, mesh_out_d;
  logic [CHANNELS-1:0]   tx_send;
  logic                  tx_fire;
  logic                  credit_ovf;
  logic                  unused_tx_flag;

  // The host's valid bit is replaced on the mesh side, so it is not consumed.
  assign unused_tx_flag = host_tx_data[VB];

  assign host_tx_ready = (credit_q[host_tx_sel] != '0);
  assign tx_fire       = host_tx_valid && host_tx_ready;

  // One-hot decode of the channel that sends this cycle.
  always_comb begin
    tx_send = '0;
    if (tx_fire) tx_send[host_tx_sel] = 1'b1;
  end

  // Per-channel credit update; a return at the ceiling is a protocol error.
  always_comb begin
    credit_ovf = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      credit_d[c] = credit_q[c];
      case ({tx_send[c], mesh_out_credits[c]})
        2'b10: credit_d[c] = credit_q[c] - CW'(1);
        2'b01: begin
          if (credit_q[c] == CW'(CREDITS)) credit_ovf = 1'b1;
          else                             credit_d[c] = credit_q[c] + CW'(1);
        end
        default: credit_d[c] = credit_q[c];
      endcase
    end
  end

  // Place the accepted flit on its slice (channel 0 at the MSB end) with the flag set.
  always_comb begin
    mesh_out_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (tx_send[c]) mesh_out_d[(CHANNELS-c)*W-1 -: W] = {1'b1, host_tx_data[VB-1:0]};
    end
  end

  // ---------------- ejection side ----------------
  logic [CHANNELS-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]        fifo_dat [CHANNELS];
  logic                fifo_ovf;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    assign fifo_push[c] = mesh_in_channels[(CHANNELS-c-1)*W + VB];

    face_fifo #(
      .WIDTH (W),
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifo_push[c]),
      .push_dat_i (mesh_in_channels[(CHANNELS-c)*W-1 -: W]),
      .pop_i      (fifo_pop[c]),
      .pop_dat_o  (fifo_dat[c]),
      .full_o     (fifo_full[c]),
      .empty_o    (fifo_empty[c])
    );
  end

  // A push is lost only when the FIFO is full and not draining in the same cycle.
  assign fifo_ovf = |(fifo_push & fifo_full & ~fifo_pop);

  logic [SW-1:0] rr_q, rr_d;
  logic [SW-1:0] grant_ch;
  logic          grant_vld;
  int            cand;

  // Round-robin search starting at the channel after the previous grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = (int'(rr_q) + k) % CHANNELS;
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = SW'(cand);
      end
    end
  end

  logic [W-1:0]        rx_data_q, rx_data_d;
  logic [SW-1:0]       rx_sel_q, rx_sel_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_load;
  logic [CHANNELS-1:0] credit_ret_q;
  logic                proto_err_q, proto_err_d;

  // The output register may refill when empty or when its flit leaves this cycle.
  assign rx_load = !rx_valid_q || host_rx_ready;

  // Pop the granted FIFO only when its head moves into the output register.
  always_comb begin
    fifo_pop = '0;
    if (rx_load && grant_vld) fifo_pop[grant_ch] = 1'b1;
  end

  // Output register, priority pointer and sticky error next-state.
  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    rx_sel_d    = rx_sel_q;
    rr_d        = rr_q;
    proto_err_d = proto_err_q || credit_ovf || fifo_ovf;
    if (rx_load) begin
      rx_valid_d = grant_vld;
      if (grant_vld) begin
        rx_data_d = fifo_dat[grant_ch];
        rx_sel_d  = grant_ch;
        rr_d      = (int'(grant_ch) == CHANNELS - 1) ? '0 : grant_ch + SW'(1);
      end
    end
  end

  // All state registers; reset drops buffered flits and in-flight credits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) credit_q[c] <= CW'(CREDITS);
      mesh_out_q   <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_sel_q     <= '0;
      rr_q         <= '0;
      credit_ret_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) credit_q[c] <= credit_d[c];
      mesh_out_q   <= mesh_out_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      rx_sel_q     <= rx_sel_d;
      rr_q         <= rr_d;
      credit_ret_q <= fifo_pop;
      proto_err_q  <= proto_err_d;
    end
  end

  assign mesh_out_channels = mesh_out_q;
  assign mesh_in_credits   = credit_ret_q;
  assign host_rx_valid     = rx_valid_q;
  assign host_rx_data      = rx_data_q;
  assign host_rx_sel       = rx_sel_q;
  assign proto_err         = proto_err_q;

endmodule

// File: tb/tb_des_network_face_adapter.sv
// Directed bench for the mesh face adapter: reset, credits, arbitration,
// backpressure and mid-operation reset, with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are read after that.
module tb_des_network_face_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mesh_in_channels;
  logic [3:0]  mesh_in_credits;
  logic [63:0] mesh_out_channels;
  logic [3:0]  mesh_out_credits;
  logic [15:0] host_tx_data;
  logic [1:0]  host_tx_sel;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [15:0] host_rx_data;
  logic [1:0]  host_rx_sel;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_network_face_adapter #(
    .CHANNELS      (4),
    .CHANNEL_WIDTH (16),
    .BUFFER_DEPTH  (4),
    .CREDITS       (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mesh_in_channels  (mesh_in_channels),
    .mesh_in_credits   (mesh_in_credits),
    .mesh_out_channels (mesh_out_channels),
    .mesh_out_credits  (mesh_out_credits),
    .host_tx_data      (host_tx_data),
    .host_tx_sel       (host_tx_sel),
    .host_tx_valid     (host_tx_valid),
    .host_tx_ready     (host_tx_ready),
    .host_rx_data      (host_rx_data),
    .host_rx_sel       (host_rx_sel),
    .host_rx_valid     (host_rx_valid),
    .host_rx_ready     (host_rx_ready),
    .proto_err         (proto_err)
  );

  // Channel c occupies the c-th 16-bit slice counted from the MSB end.
  function automatic logic [63:0] put(input int c, input logic [15:0] flit);
    logic [63:0] v;
    v = '0;
    v[(4-c)*16-1 -: 16] = flit;
    return v;
  endfunction

  function automatic logic [15:0] rr_flit(input int c, input int i);
    return {4'h8, 4'(c), 8'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mesh_in_channels = '0;
    mesh_out_credits = '0;
    host_tx_data     = '0;
    host_tx_sel      = '0;
    host_tx_valid    = 1'b0;
    host_rx_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mesh_out_channels !== 64'h0) begin errors++; $display("FAIL reset_mesh_out: got %h expected 0", mesh_out_channels); end
    checks++; if (mesh_in_credits !== 4'h0) begin errors++; $display("FAIL reset_credits: got %b expected 0000", mesh_in_credits); end
    checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", host_rx_valid); end
    checks++; if (host_rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data: got %h expected 0", host_rx_data); end
    checks++; if (host_rx_sel !== 2'd0) begin errors++; $display("FAIL reset_rx_sel: got %0d expected 0", host_rx_sel); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      host_tx_sel = 2'(s);
      #1;
      checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready ch%0d: got %b expected 1", s, host_tx_ready); end
    end
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    host_tx_sel   = 2'd2;
    host_tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_tx_data = 16'h0A00 + 16'(i);
      #1;
      checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL exh_ready%0d: got %b expected 1", i, host_tx_ready); end
      tick();
      checks++; if (mesh_out_channels !== put(2, 16'h8A00 + 16'(i))) begin errors++; $display("FAIL exh_flit%0d: got %h expected %h", i, mesh_out_channels, put(2, 16'h8A00 + 16'(i))); end
    end
    host_tx_data = 16'h0A04;
    #1;
    checks++; if (host_tx_ready !== 1'b0) begin errors++; $display("FAIL exh_ready_5th: got %b expected 0", host_tx_ready); end
    tick();
    checks++; if (mesh_out_channels !== 64'h0) begin errors++; $display("FAIL exh_no_flit: got %h expected 0", mesh_out_channels); end
    mesh_out_credits = 4'b0100;
    tick();
    mesh_out_credits = 4'b0000;
    checks++; if (mesh_out_channels !== 64'h0) begin errors++; $display("FAIL exh_no_flit_ret: got %h expected 0", mesh_out_channels); end
    #1;
    checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL exh_ready_after_ret: got %b expected 1", host_tx_ready); end
    tick();
    checks++; if (mesh_out_channels !== put(2, 16'h8A04)) begin errors++; $display("FAIL exh_flit5: got %h expected %h", mesh_out_channels, put(2, 16'h8A04)); end
    host_tx_valid = 1'b0;
    #1;
    checks++; if (host_tx_ready !== 1'b0) begin errors++; $display("FAIL exh_ready_final: got %b expected 0", host_tx_ready); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL exh_proto_err: got %b expected 0", proto_err); end
  endtask

  task automatic test_simultaneous_credit();
    do_reset();
    host_tx_sel   = 2'd1;
    host_tx_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      host_tx_data = 16'h0100 + 16'(i);
      tick();
    end
    host_tx_data     = 16'h0102;
    mesh_out_credits = 4'b0010;
    #1;
    checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b expected 1", host_tx_ready); end
    tick();
    mesh_out_credits = 4'b0000;
    checks++; if (mesh_out_channels !== put(1, 16'h8102)) begin errors++; $display("FAIL sim_flit: got %h expected %h", mesh_out_channels, put(1, 16'h8102)); end
    for (int i = 0; i < 2; i++) begin
      host_tx_data = 16'h0103 + 16'(i);
      #1;
      checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL sim_left%0d: got %b expected 1", i, host_tx_ready); end
      tick();
    end
    #1;
    checks++; if (host_tx_ready !== 1'b0) begin errors++; $display("FAIL sim_empty: got %b expected 0", host_tx_ready); end
    host_tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mesh_out_credits = 4'b0010;
      tick();
    end
    mesh_out_credits = 4'b0000;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL sim_refill_err: got %b expected 0", proto_err); end
    checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL sim_refill_ready: got %b expected 1", host_tx_ready); end
    mesh_out_credits = 4'b0010;
    tick();
    mesh_out_credits = 4'b0000;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL sim_spurious_err: got %b expected 1", proto_err); end
    repeat (3) tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL sim_err_sticky: got %b expected 1", proto_err); end
  endtask

  task automatic test_round_robin();
    int exp_ch;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mesh_in_channels = put(0, rr_flit(0, i)) | put(1, rr_flit(1, i)) | put(3, rr_flit(3, i));
      tick();
      if (i == 1) begin
        checks++; if (mesh_in_credits !== 4'b0001) begin errors++; $display("FAIL rr_first_credit: got %b expected 0001", mesh_in_credits); end
        checks++; if (host_rx_data !== rr_flit(0, 0)) begin errors++; $display("FAIL rr_first_data: got %h expected %h", host_rx_data, rr_flit(0, 0)); end
      end
    end
    mesh_in_channels = '0;
    checks++; if (mesh_in_credits !== 4'b0000) begin errors++; $display("FAIL rr_credit_once: got %b expected 0000", mesh_in_credits); end
    checks++; if (host_rx_valid !== 1'b1 || host_rx_sel !== 2'd0) begin errors++; $display("FAIL rr_held: got v=%b sel=%0d expected v=1 sel=0", host_rx_valid, host_rx_sel); end
    host_rx_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      tick();
      exp_ch = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 1 : 3);
      checks++; if (host_rx_valid !== 1'b1 || host_rx_sel !== 2'(exp_ch) || host_rx_data !== rr_flit(exp_ch, k / 3)) begin
        errors++; $display("FAIL rr_grant%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", k, host_rx_valid, host_rx_sel, host_rx_data, exp_ch, rr_flit(exp_ch, k / 3));
      end
      checks++; if (mesh_in_credits !== 4'(1 << exp_ch)) begin errors++; $display("FAIL rr_credit%0d: got %b expected %b", k, mesh_in_credits, 4'(1 << exp_ch)); end
    end
    tick();
    checks++; if (host_rx_valid !== 1'b0 || mesh_in_credits !== 4'b0000) begin errors++; $display("FAIL rr_drained: got v=%b cred=%b expected v=0 cred=0000", host_rx_valid, mesh_in_credits); end
    host_rx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mesh_in_channels = put(1, 16'h81AA);
    tick();
    mesh_in_channels = '0;
    tick();
    checks++; if (host_rx_valid !== 1'b1 || host_rx_sel !== 2'd1 || host_rx_data !== 16'h81AA) begin errors++; $display("FAIL bp_load: got v=%b sel=%0d data=%h expected v=1 sel=1 data=81aa", host_rx_valid, host_rx_sel, host_rx_data); end
    checks++; if (mesh_in_credits !== 4'b0010) begin errors++; $display("FAIL bp_load_credit: got %b expected 0010", mesh_in_credits); end
    tick();
    for (int i = 0; i < 10; i++) begin
      mesh_in_channels = (i < 4) ? put(0, 16'h80B0 + 16'(i)) : 64'h0;
      tick();
      checks++; if (host_rx_valid !== 1'b1 || host_rx_sel !== 2'd1 || host_rx_data !== 16'h81AA) begin errors++; $display("FAIL bp_hold%0d: got v=%b sel=%0d data=%h expected v=1 sel=1 data=81aa", i, host_rx_valid, host_rx_sel, host_rx_data); end
      checks++; if (mesh_in_credits !== 4'b0000 || proto_err !== 1'b0) begin errors++; $display("FAIL bp_quiet%0d: got cred=%b err=%b expected cred=0000 err=0", i, mesh_in_credits, proto_err); end
    end
    mesh_in_channels = put(0, 16'h80B4);
    tick();
    mesh_in_channels = '0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b expected 1", proto_err); end
    host_rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (host_rx_valid !== 1'b1 || host_rx_sel !== 2'd0 || host_rx_data !== 16'h80B0 + 16'(i)) begin errors++; $display("FAIL bp_drain%0d: got v=%b sel=%0d data=%h expected v=1 sel=0 data=%h", i, host_rx_valid, host_rx_sel, host_rx_data, 16'h80B0 + 16'(i)); end
    end
    tick();
    checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL bp_dropped: got v=%b data=%h expected v=0", host_rx_valid, host_rx_data); end
    host_rx_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      mesh_in_channels = put(2, 16'h8200 + 16'(i));
      tick();
    end
    mesh_in_channels = '0;
    host_tx_sel      = 2'd3;
    host_tx_valid    = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      host_tx_data = 16'h0300 + 16'(i);
      tick();
    end
    checks++; if (mesh_out_channels !== put(3, 16'h8303)) begin errors++; $display("FAIL mid_pre_out: got %h expected %h", mesh_out_channels, put(3, 16'h8303)); end
    checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== 16'h8201) begin errors++; $display("FAIL mid_pre_rx: got v=%b data=%h expected v=1 data=8201", host_rx_valid, host_rx_data); end
    host_tx_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (mesh_out_channels !== 64'h0 || mesh_in_credits !== 4'h0) begin errors++; $display("FAIL mid_async_mesh: got out=%h cred=%b expected 0", mesh_out_channels, mesh_in_credits); end
    checks++; if (host_rx_valid !== 1'b0 || host_rx_data !== 16'h0 || host_rx_sel !== 2'd0) begin errors++; $display("FAIL mid_async_rx: got v=%b data=%h sel=%0d expected 0", host_rx_valid, host_rx_data, host_rx_sel); end
    repeat (2) @(posedge clk);
    #1;
    reset         = 1'b1;
    host_rx_ready = 1'b1;
    host_tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_tx_data = 16'h0310 + 16'(i);
      #1;
      checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL mid_credit%0d: got %b expected 1", i, host_tx_ready); end
      tick();
      checks++; if (host_rx_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got v=%b data=%h expected v=0", i, host_rx_valid, host_rx_data); end
    end
    #1;
    checks++; if (host_tx_ready !== 1'b0) begin errors++; $display("FAIL mid_credit_limit: got %b expected 0", host_tx_ready); end
    host_tx_valid = 1'b0;
    repeat (3) tick();
    checks++; if (host_rx_valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL mid_quiet: got v=%b err=%b expected v=0 err=0", host_rx_valid, proto_err); end
  endtask

  initial begin
    test_reset();
    test_credit_exhaustion();
    test_simultaneous_credit();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
